// File: rtl/unlock_seq.sv
// Command gate: a three-code unlock sequence guards forwarding of 3-bit codes.
// Repeated wrong codes trip a timed lockout; illegal states fall back to IDLE.
module unlock_seq #(
  parameter logic [2:0] KEY0 = 3'd5,
  parameter logic [2:0] KEY1 = 3'd2,
  parameter logic [2:0] KEY2 = 3'd6,
  parameter int MAX_FAIL = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic       out_valid,
  output logic [2:0] out_code,
  output logic       unlocked,
  output logic       locked_out,
  output logic [1:0] fail_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_K1   = 3'd1;
  localparam logic [2:0] S_K2   = 3'd2;
  localparam logic [2:0] S_UNL  = 3'd3;
  localparam logic [2:0] S_LOCK = 3'd4;
  localparam logic [2:0] RELOCK = 3'b111;

  localparam logic [7:0] TLOAD = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0] MF    = 2'(MAX_FAIL);

  logic [2:0] state, state_n;
  logic [7:0] timer, timer_n;
  logic [1:0] fail_q, fail_n;
  logic       fwd;
  logic       accept;
  logic       fail_hit;
  logic [2:0] exp_key;

  assign in_ready   = (state != S_LOCK);
  assign accept     = in_valid && in_ready;
  assign unlocked   = (state == S_UNL);
  assign locked_out = (state == S_LOCK);
  assign fail_cnt   = fail_q;

  // Any failure that reaches the limit trips the lockout.
  assign fail_hit = ({1'b0, fail_q} + 3'd1) >= {1'b0, MF};

  always_comb begin
    exp_key = KEY0;
    unique case (1'b1)
      (state == S_K1): exp_key = KEY1;
      (state == S_K2): exp_key = KEY2;
      default:         exp_key = KEY0;
    endcase
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    fail_n  = fail_q;
    fwd     = 1'b0;
    case (state)
      S_IDLE, S_K1, S_K2: begin
        if (accept) begin
          if (in_code == exp_key) begin
            if (state == S_K2) begin
              state_n = S_UNL;
              fail_n  = 2'd0;
            end else begin
              state_n = state + 3'd1;
            end
          end else if (fail_hit) begin
            state_n = S_LOCK;
            timer_n = TLOAD;
            fail_n  = MF;
          end else begin
            state_n = S_IDLE;
            fail_n  = fail_q + 2'd1;
          end
        end
      end
      S_UNL: begin
        if (accept) begin
          if (in_code == RELOCK) state_n = S_IDLE;
          else fwd = 1'b1;
        end
      end
      S_LOCK: begin
        if (timer == 8'd0) begin
          state_n = S_IDLE;
          fail_n  = 2'd0;
        end else begin
          timer_n = timer - 8'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = 8'd0;
        fail_n  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= 8'd0;
      fail_q    <= 2'd0;
      out_valid <= 1'b0;
      out_code  <= 3'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      fail_q    <= fail_n;
      out_valid <= fwd;
      out_code  <= fwd ? in_code : 3'd0;
    end
  end

endmodule

// File: doc/unlock_seq.md
# unlock_seq

Upstream command gate for the output FSM: accepts 3-bit user command codes over a valid/ready handshake, requires a three-code unlock sequence before forwarding anything, and forwards accepted codes as a one-cycle `out_valid`/`out_code` pulse to the downstream FSM's 3-bit user input. The block is fail-safe. Wrong codes count toward a lockout, and the FSM, lockout timer and failure counter all return to the locked state on reset or on any illegal encoding.

## Interface
- `KEY0`, default 3'd5: first unlock code. Must not be 3'b111.
- `KEY1`, default 3'd2: second unlock code. Must not be 3'b111.
- `KEY2`, default 3'd6: third unlock code. Must not be 3'b111.
- `MAX_FAIL`, default 3: consecutive failures that trigger lockout. Legal range 1..3.
- `LOCKOUT_CYCLES`, default 16: lockout duration in clocks. Legal range 1..256.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the upstream command is present.
- `in_code` input 3: the command code.
- `in_ready` output 1: the block can accept a command. It is combinational and equals `state != LOCKOUT`.
- `out_valid` output 1: one-cycle pulse that marks a forwarded code.
- `out_code` output 3: the forwarded code. It is 0 whenever `out_valid` is 0.
- `unlocked` output 1: high while `state == UNLOCKED`.
- `locked_out` output 1: high while `state == LOCKOUT`.
- `fail_cnt` output 2: current consecutive-failure count.

## Operation
- The state register is 3 bits with these states: IDLE=0, K1=1, K2=2, UNLOCKED=3, LOCKOUT=4. Encodings 5..7 go to IDLE on the next clock with all outputs inactive.
- An accept is `in_valid && in_ready`. Only accepts change state, except in LOCKOUT, which is timer-driven.
- Unlock sequence:
  - IDLE: `KEY0` goes to K1. Any other code is a failure.
  - K1: `KEY1` goes to K2. Any other code is a failure.
  - K2: `KEY2` goes to UNLOCKED and clears `fail_cnt`. Any other code is a failure.
- Failure handling:
  - If `fail_cnt + 1 == MAX_FAIL`: go to LOCKOUT, load the timer with `LOCKOUT_CYCLES - 1`, and set `fail_cnt` to `MAX_FAIL`.
  - Otherwise: increment `fail_cnt` and go to IDLE.
- LOCKOUT:
  - `in_ready = 0`, so `in_valid` is ignored.
  - When the timer is 0: go to IDLE and clear `fail_cnt`.
  - Otherwise: decrement the timer.
- UNLOCKED:
  - An accepted code other than 3'b111 is forwarded, with `out_code = in_code` and `out_valid = 1` on the next cycle.
  - 3'b111 is the relock command: go to IDLE and do not forward it.
  - Accepted codes never count as failures in this state.
- Nothing is forwarded in any state except UNLOCKED.
- The timer is 8 bits and wraps are impossible within the legal parameter range. `fail_cnt` saturates at `MAX_FAIL`.
- Reset values: state IDLE; timer 0; `fail_cnt` 0; `out_valid` 0; `out_code` 0; `unlocked` 0; `locked_out` 0; `in_ready` 1.
- Reset mid-sequence or mid-lockout: the lock state is abandoned immediately, with no residual count and no forward.

## Timing
- Accept at edge t: the new state is visible after t, so `unlocked` and `locked_out` change in cycle t+1.
- Forward latency is 1 cycle. A code accepted at t appears as `out_valid`/`out_code` during t+1 only.
- Back-to-back accepts in UNLOCKED produce back-to-back `out_valid` pulses. Throughput is one code per clock.
- Lockout timing for the failure that triggers it, accepted at t:
  - `locked_out` is high in cycles t+1 .. t+LOCKOUT_CYCLES.
  - The block is in IDLE, with `in_ready = 1` and `fail_cnt = 0`, in cycle t+LOCKOUT_CYCLES+1.
- The relock code accepted at t: `unlocked` falls in t+1, and `out_valid` stays 0.
- Reset has priority over every other event in the same cycle. If `rst` and an accept occur together, the accept is discarded.

## Test plan
- Reset, then accepts 5, 2, 6: `unlocked` rises the cycle after the 6, `fail_cnt = 0`, and `out_valid` is 0 throughout.
- Unlocked, then accepts 3, 0, 4 in consecutive cycles: `out_valid` is high for 3 cycles with `out_code` = 3, 0, 4, each one cycle after its accept. Then accept 7: `unlocked` falls and there is no pulse.
- Accepts 5, 1 (fail), 0 (fail), 5, 2, 4 (fail): `locked_out` is high for exactly 16 cycles with `in_ready = 0`, and codes driven during that window are ignored. Afterwards `fail_cnt = 0` and 5, 2, 6 unlocks.
- Accepts 5, 3 (fail, `fail_cnt = 1`), 5, 2, 6: the block unlocks and `fail_cnt` returns to 0.
- Assert `rst` during lockout, and separately during K2: the block returns next cycle to IDLE with every output at its reset value. A 5, 2, 6 sequence started afterwards unlocks.
- Force state encodings 5, 6 and 7 (via `force`): IDLE next cycle, `out_valid` 0, `unlocked` 0.
